// File: rtl/sub8_pkg.sv
// Shared types and widths for the nibble-serial 8-bit subtractor.
package sub8_pkg;

    localparam int DATA_W = 8;
    localparam int NIB_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

endpackage

// File: rtl/sub4_slice.sv
// Combinational 4-bit borrow slice: {bout, d} = a - b - bin.
module sub4_slice
    import sub8_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             bin,
    output logic [NIB_W-1:0] d,
    output logic             bout
);

    logic [NIB_W:0] full;

    // The extra top bit of the widened difference is set exactly when the result went negative.
    assign full = {1'b0, a} - {1'b0, b} - {{NIB_W{1'b0}}, bin};
    assign d    = full[NIB_W-1:0];
    assign bout = full[NIB_W];

endmodule

// File: rtl/sub8_serial.sv
// Nibble-serial 8-bit subtractor, Diff = A - B - Bin, with valid/ready on both sides.
// Define SUB8_OVF_EN to add the signed-overflow output ovf.
module sub8_serial
    import sub8_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              Bin,
    output logic [DATA_W-1:0] Diff,
    output logic              Bout,
`ifdef SUB8_OVF_EN
    output logic              ovf,
`endif
    output logic              out_valid,
    input  logic              out_ready
);

    state_t state, next_state;

    logic [DATA_W-1:0] a_r, b_r;
    logic              bin_r;
    logic              nib_borrow;
    logic [DATA_W-1:0] diff_r;
    logic              bout_r;
`ifdef SUB8_OVF_EN
    logic              ovf_r;
`endif

    logic [NIB_W-1:0] slice_a, slice_b, slice_d;
    logic             slice_bin, slice_bout;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: defaults come first so no path through the case leaves an output unassigned (no latch).
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = LO;
            end
            LO:   next_state = HI;
            HI:   next_state = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // One slice serves both nibbles; the high pass chains the borrow from the low pass.
    always_comb begin
        slice_a   = a_r[NIB_W-1:0];
        slice_b   = b_r[NIB_W-1:0];
        slice_bin = bin_r;
        if (state == HI) begin
            slice_a   = a_r[DATA_W-1:NIB_W];
            slice_b   = b_r[DATA_W-1:NIB_W];
            slice_bin = nib_borrow;
        end
    end

    sub4_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .bin  (slice_bin),
        .d    (slice_d),
        .bout (slice_bout)
    );

    // NOTE: operand registers are reset along with the results; it costs little and keeps every visible value defined.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r        <= '0;
            b_r        <= '0;
            bin_r      <= 1'b0;
            nib_borrow <= 1'b0;
            diff_r     <= '0;
            bout_r     <= 1'b0;
`ifdef SUB8_OVF_EN
            ovf_r      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= A;
                        b_r   <= B;
                        bin_r <= Bin;
                    end
                end
                LO: begin
                    diff_r[NIB_W-1:0] <= slice_d;
                    nib_borrow        <= slice_bout;
                end
                HI: begin
                    diff_r[DATA_W-1:NIB_W] <= slice_d;
                    bout_r                 <= slice_bout;
`ifdef SUB8_OVF_EN
                    // Operands of opposite sign whose result sign differs from the minuend.
                    ovf_r <= (a_r[DATA_W-1] != b_r[DATA_W-1]) &&
                             (slice_d[NIB_W-1] != a_r[DATA_W-1]);
`endif
                end
                default: ;
            endcase
        end
    end

    assign Diff = diff_r;
    assign Bout = bout_r;
`ifdef SUB8_OVF_EN
    assign ovf  = ovf_r;
`endif

endmodule
